mem_arbiter: RTL and testbench

//  Shares one fixed-latency, single-port backing memory between the fetch stage
//  (instruction reads) and the memory stage (data loads/stores) of the 5-stage cpu.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arb_pick.sv | 22 ++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and payload types for the fetch/data memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requests with the data-streak limit.
module mem_arb_pick #(
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned STREAK_W        = 3
) (
    input  logic                if_req,
    input  logic                d_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant_valid_c,
    output logic                grant_d_c,
    output logic                contested_c
);

    logic limit_hit;

    // Fetch only wins a contested pick once data has used up its streak.
    assign limit_hit     = (streak == STREAK_W'(MAX_DATA_STREAK));
    assign contested_c   = if_req & d_req;
    assign grant_valid_c = if_req | d_req;
    assign grant_d_c     = d_req & (~if_req | ~limit_hit);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data accesses onto one fixed-latency single-port memory.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_stall,
    output logic              d_stall,
    output logic              busy
);

    localparam int unsigned CNT_W    = $clog2(LATENCY + 1);
    localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);

    logic [1:0]          state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [STREAK_W-1:0] streak, streak_nxt;
    logic                owner, owner_nxt;
    mem_req_t            req_q, req_nxt;
    logic                mem_en_nxt;
    logic                if_ack_nxt, d_ack_nxt;
    logic [DATA_W-1:0]   if_rdata_nxt, d_rdata_nxt;

    logic grant_valid_c, grant_d_c, contested_c;

    mem_arb_pick #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK),
        .STREAK_W        (STREAK_W)
    ) u_pick (
        .if_req        (if_req),
        .d_req         (d_req),
        .streak        (streak),
        .grant_valid_c (grant_valid_c),
        .grant_d_c     (grant_d_c),
        .contested_c   (contested_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        streak_nxt   = streak;
        owner_nxt    = owner;
        req_nxt      = req_q;
        mem_en_nxt   = 1'b0;
        if_ack_nxt   = 1'b0;
        d_ack_nxt    = 1'b0;
        if_rdata_nxt = if_rdata;
        d_rdata_nxt  = d_rdata;

        case (state)
            ST_IDLE: begin
                if (grant_valid_c) begin
                    state_nxt  = ST_ISSUE;
                    mem_en_nxt = 1'b1;
                    if (grant_d_c) begin
                        owner_nxt = OWN_D;
                        req_nxt   = '{we: d_we, addr: d_addr, wdata: d_wdata};
                        if (contested_c) begin
                            if (streak != STREAK_W'(MAX_DATA_STREAK)) begin
                                streak_nxt = streak + STREAK_W'(1);
                            end
                        end else begin
                            streak_nxt = '0;
                        end
                    end else begin
                        owner_nxt  = OWN_IF;
                        req_nxt    = '{we: 1'b0, addr: if_addr, wdata: '0};
                        streak_nxt = '0;
                    end
                end
            end
            ST_ISSUE: begin
                // The WAIT countdown always lands its last cycle on the data-valid edge.
                cnt_nxt   = CNT_W'(LATENCY - 1);
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_RESP;
                    if (owner == OWN_D) begin
                        d_ack_nxt = 1'b1;
                        if (!req_q.we) begin
                            d_rdata_nxt = mem_rdata;
                        end
                    end else begin
                        if_ack_nxt   = 1'b1;
                        if_rdata_nxt = mem_rdata;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            streak   <= '0;
            owner    <= OWN_IF;
            req_q    <= '0;
            mem_en   <= 1'b0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            streak   <= streak_nxt;
            owner    <= owner_nxt;
            req_q    <= req_nxt;
            mem_en   <= mem_en_nxt;
            if_ack   <= if_ack_nxt;
            d_ack    <= d_ack_nxt;
            if_rdata <= if_rdata_nxt;
            d_rdata  <= d_rdata_nxt;
        end
    end

    assign mem_we    = req_q.we;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign busy      = (state != ST_IDLE);
    assign if_stall  = if_req & ~if_ack;
    assign d_stall   = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus multi-cycle corner sequences.
module tb_mem_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        if_stall;
    logic        d_stall;
    logic        busy;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.LATENCY(2), .MAX_DATA_STREAK(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .if_stall  (if_stall),
        .d_stall   (d_stall),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Backing memory: read data appears exactly two cycles after mem_en.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return a * 32'd3 + 32'h1000_0001;
    endfunction

    logic [31:0] p1 = 32'hBAD0BAD0;
    logic [31:0] p2 = 32'hBAD0BAD0;
    assign mem_rdata = p2;
    always @(posedge clk) begin
        p1 <= (mem_en && !mem_we) ? mem_model(mem_addr) : 32'hBAD0BAD0;
        p2 <= p1;
    end

    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        e_if_ack;
        logic        e_d_ack;
        logic        e_mem_en;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic [31:0] e_mem_wdata;
        logic [31:0] e_if_rdata;
        logic [31:0] e_d_rdata;
        logic        e_if_stall;
        logic        e_d_stall;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mk(
        input logic ifr, input logic [31:0] ifa, input logic dr, input logic dwe,
        input logic [31:0] da, input logic [31:0] dwd,
        input logic ia, input logic dk, input logic en, input logic we,
        input logic [31:0] ma, input logic [31:0] mw, input logic [31:0] ird,
        input logic [31:0] drd, input logic ist, input logic dst, input logic bsy);
        vec_t v;
        v.ifr = ifr; v.ifa = ifa; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd;
        v.e_if_ack = ia; v.e_d_ack = dk; v.e_mem_en = en; v.e_mem_we = we;
        v.e_mem_addr = ma; v.e_mem_wdata = mw; v.e_if_rdata = ird; v.e_d_rdata = drd;
        v.e_if_stall = ist; v.e_d_stall = dst; v.e_busy = bsy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Single fetch with nominal timing: mem_en at cycle 1, if_ack at cycle 4.
    task automatic run_fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        if_req = 1'b1;
        if_addr = addr;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("%s.c%0d.mem_en", tag, c), mem_en, (c == 1) ? 32'h1 : 32'h0);
            chk($sformatf("%s.c%0d.if_ack", tag, c), if_ack, (c == 4) ? 32'h1 : 32'h0);
            if (c == 1) chk($sformatf("%s.mem_addr", tag), mem_addr, addr);
        end
        chk($sformatf("%s.if_rdata", tag), if_rdata, exp);
        if_req = 1'b0;
    endtask

    vec_t vecs [23];

    initial begin
        vec_t        v;
        int          n;
        int          gcyc [6];
        logic [31:0] gaddr [6];
        logic [31:0] exp_order [6];

        // Test 1: single fetch; test 2: contested pair; test 4: store.
        vecs[0]  = mk(H,32'h10,L,L,32'h0,32'h0,     L,L,L,L,32'h00,32'h0,   32'h0,       32'h0,       H,L,L);
        vecs[1]  = mk(H,32'h10,L,L,32'h0,32'h0,     L,L,H,L,32'h10,32'h0,   32'h0,       32'h0,       H,L,H);
        vecs[2]  = mk(H,32'h10,L,L,32'h0,32'h0,     L,L,L,L,32'h10,32'h0,   32'h0,       32'h0,       H,L,H);
        vecs[3]  = mk(H,32'h10,L,L,32'h0,32'h0,     L,L,L,L,32'h10,32'h0,   32'h0,       32'h0,       H,L,H);
        vecs[4]  = mk(H,32'h10,L,L,32'h0,32'h0,     H,L,L,L,32'h10,32'h0,   32'hDEADBEEF,32'h0,       L,L,H);
        vecs[5]  = mk(L,32'h10,L,L,32'h0,32'h0,     L,L,L,L,32'h10,32'h0,   32'hDEADBEEF,32'h0,       L,L,L);
        vecs[6]  = mk(H,32'h20,H,L,32'h80,32'h0,    L,L,L,L,32'h10,32'h0,   32'hDEADBEEF,32'h0,       H,H,L);
        vecs[7]  = mk(H,32'h20,H,L,32'h80,32'h0,    L,L,H,L,32'h80,32'h0,   32'hDEADBEEF,32'h0,       H,H,H);
        vecs[8]  = mk(H,32'h20,H,L,32'h80,32'h0,    L,L,L,L,32'h80,32'h0,   32'hDEADBEEF,32'h0,       H,H,H);
        vecs[9]  = mk(H,32'h20,H,L,32'h80,32'h0,    L,L,L,L,32'h80,32'h0,   32'hDEADBEEF,32'h0,       H,H,H);
        vecs[10] = mk(H,32'h20,H,L,32'h80,32'h0,    L,H,L,L,32'h80,32'h0,   32'hDEADBEEF,32'h10000181,H,L,H);
        vecs[11] = mk(H,32'h20,L,L,32'h80,32'h0,    L,L,L,L,32'h80,32'h0,   32'hDEADBEEF,32'h10000181,H,L,L);
        vecs[12] = mk(H,32'h20,L,L,32'h80,32'h0,    L,L,H,L,32'h20,32'h0,   32'hDEADBEEF,32'h10000181,H,L,H);
        vecs[13] = mk(H,32'h20,L,L,32'h80,32'h0,    L,L,L,L,32'h20,32'h0,   32'hDEADBEEF,32'h10000181,H,L,H);
        vecs[14] = mk(H,32'h20,L,L,32'h80,32'h0,    L,L,L,L,32'h20,32'h0,   32'hDEADBEEF,32'h10000181,H,L,H);
        vecs[15] = mk(H,32'h20,L,L,32'h80,32'h0,    H,L,L,L,32'h20,32'h0,   32'h10000061,32'h10000181,L,L,H);
        vecs[16] = mk(L,32'h20,L,L,32'h80,32'h0,    L,L,L,L,32'h20,32'h0,   32'h10000061,32'h10000181,L,L,L);
        vecs[17] = mk(L,32'h20,H,H,32'h40,32'h1234, L,L,L,L,32'h20,32'h0,   32'h10000061,32'h10000181,L,H,L);
        vecs[18] = mk(L,32'h20,H,H,32'h40,32'h1234, L,L,H,H,32'h40,32'h1234,32'h10000061,32'h10000181,L,H,H);
        vecs[19] = mk(L,32'h20,H,H,32'h40,32'h1234, L,L,L,H,32'h40,32'h1234,32'h10000061,32'h10000181,L,H,H);
        vecs[20] = mk(L,32'h20,H,H,32'h40,32'h1234, L,L,L,H,32'h40,32'h1234,32'h10000061,32'h10000181,L,H,H);
        vecs[21] = mk(L,32'h20,H,H,32'h40,32'h1234, L,H,L,H,32'h40,32'h1234,32'h10000061,32'h10000181,L,L,H);
        vecs[22] = mk(L,32'h20,L,L,32'h40,32'h1234, L,L,L,H,32'h40,32'h1234,32'h10000061,32'h10000181,L,L,L);

        exp_order = '{32'h200, 32'h200, 32'h100, 32'h200, 32'h200, 32'h100};

        // Reset values while reset is held low.
        #1;
        chk("rst.if_ack", if_ack, 32'h0);
        chk("rst.d_ack", d_ack, 32'h0);
        chk("rst.mem_en", mem_en, 32'h0);
        chk("rst.mem_we", mem_we, 32'h0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.mem_wdata", mem_wdata, 32'h0);
        chk("rst.if_rdata", if_rdata, 32'h0);
        chk("rst.d_rdata", d_rdata, 32'h0);
        chk("rst.busy", busy, 32'h0);
        do_reset();

        for (int i = 0; i < 23; i++) begin
            v = vecs[i];
            @(negedge clk);
            if_req = v.ifr; if_addr = v.ifa; d_req = v.dr; d_we = v.dwe;
            d_addr = v.da; d_wdata = v.dwd;
            #1;
            chk($sformatf("v%0d.if_ack", i), if_ack, v.e_if_ack);
            chk($sformatf("v%0d.d_ack", i), d_ack, v.e_d_ack);
            chk($sformatf("v%0d.mem_en", i), mem_en, v.e_mem_en);
            chk($sformatf("v%0d.mem_we", i), mem_we, v.e_mem_we);
            chk($sformatf("v%0d.mem_addr", i), mem_addr, v.e_mem_addr);
            chk($sformatf("v%0d.mem_wdata", i), mem_wdata, v.e_mem_wdata);
            chk($sformatf("v%0d.if_rdata", i), if_rdata, v.e_if_rdata);
            chk($sformatf("v%0d.d_rdata", i), d_rdata, v.e_d_rdata);
            chk($sformatf("v%0d.if_stall", i), if_stall, v.e_if_stall);
            chk($sformatf("v%0d.d_stall", i), d_stall, v.e_d_stall);
            chk($sformatf("v%0d.busy", i), busy, v.e_busy);
        end

        // Test 3: both requests held, streak limit forces D,D,I,D,D,I.
        do_reset();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = 32'h0;
        n = 0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(posedge clk);
            #1;
            if (mem_en === 1'b1) begin
                gaddr[n] = mem_addr;
                gcyc[n] = c;
                n++;
            end
        end
        chk("t3.grants", n, 6);
        for (int i = 0; i < n; i++) chk($sformatf("t3.order%0d", i), gaddr[i], exp_order[i]);
        for (int i = 1; i < n; i++) chk($sformatf("t3.gap%0d", i), gcyc[i] - gcyc[i-1], 5);
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0;
        for (int c = 0; c < 10 && busy; c++) @(negedge clk);
        #1;
        chk("t3.drain", busy, 32'h0);

        // Test 5: reset during WAIT aborts with no ack; service resumes normally.
        do_reset();
        run_fetch("t5a", 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h50;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("t5.in_wait", busy, 32'h1);
        reset = 1'b0;
        #1;
        chk("t5.if_ack", if_ack, 32'h0);
        chk("t5.d_ack", d_ack, 32'h0);
        chk("t5.mem_en", mem_en, 32'h0);
        chk("t5.mem_we", mem_we, 32'h0);
        chk("t5.mem_addr", mem_addr, 32'h0);
        chk("t5.mem_wdata", mem_wdata, 32'h0);
        chk("t5.if_rdata", if_rdata, 32'h0);
        chk("t5.d_rdata", d_rdata, 32'h0);
        chk("t5.busy", busy, 32'h0);
        chk("t5.if_stall", if_stall, 32'h1);
        if_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            if (if_ack === 1'b1 || mem_en === 1'b1) n++;
        end
        chk("t5.no_ack", n, 0);
        chk("t5.rdata_kept", if_rdata, 32'h0);
        run_fetch("t5b", 32'h10, 32'hDEADBEEF);

        // Test 6: fetch dropped after ISSUE still acks; data granted next IDLE.
        @(negedge clk);
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h30;
        @(negedge clk);
        #1;
        chk("t6.c1.mem_en", mem_en, 32'h1);
        chk("t6.c1.mem_addr", mem_addr, 32'h30);
        for (int c = 2; c <= 9; c++) begin
            @(negedge clk);
            if (c == 2) begin
                if_req = 1'b0;
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90;
            end
            #1;
            chk($sformatf("t6.c%0d.if_ack", c), if_ack, (c == 4) ? 32'h1 : 32'h0);
            chk($sformatf("t6.c%0d.mem_en", c), mem_en, (c == 6) ? 32'h1 : 32'h0);
            chk($sformatf("t6.c%0d.d_ack", c), d_ack, (c == 9) ? 32'h1 : 32'h0);
            if (c == 4) chk("t6.if_rdata", if_rdata, 32'h10000091);
            if (c == 5) chk("t6.d_stall", d_stall, 32'h1);
            if (c == 6) chk("t6.mem_addr", mem_addr, 32'h90);
            if (c == 9) chk("t6.d_rdata", d_rdata, 32'h100001B1);
        end
        d_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
